// File: rtl/gcd_client_pkg.sv
// Shared field layout for the GCD client command and request messages.
// Storage widths grow when GCD_CLIENT_ERR_CAPTURE_EN is defined.
package gcd_client_pkg;

    localparam int OPND_W      = 16;
    localparam int CMD_W       = 48;
    localparam int REQ_W       = 32;

    localparam int CMD_A_LSB   = 32;
    localparam int CMD_B_LSB   = 16;
    localparam int CMD_EXP_LSB = 0;

    localparam int REQ_A_LSB   = 16;
    localparam int REQ_B_LSB   = 0;

`ifdef GCD_CLIENT_ERR_CAPTURE_EN
    // The expected queue keeps the whole command so operands can be reported.
    localparam int EXP_W = CMD_W;
`else
    localparam int EXP_W = OPND_W;
`endif

    function automatic logic [REQ_W-1:0] cmd_req_part(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_B_LSB +: REQ_W];
    endfunction

    function automatic logic [OPND_W-1:0] cmd_expected(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_EXP_LSB +: OPND_W];
    endfunction

    function automatic logic [OPND_W-1:0] req_a(input logic [REQ_W-1:0] req);
        return req[REQ_A_LSB +: OPND_W];
    endfunction

    function automatic logic [OPND_W-1:0] req_b(input logic [REQ_W-1:0] req);
        return req[REQ_B_LSB +: OPND_W];
    endfunction

endpackage

// File: rtl/gcd_client_fifo.sv
// Synchronous FIFO for the request and expected-result queues.
// Push is ignored when full, pop is ignored when empty; push and pop may coincide.
module gcd_client_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

    // Read and write pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/gcd_client.sv
// GCD test client: queues commands, issues GCD requests and checks results in order.
// Optional first-mismatch capture ports are enabled by GCD_CLIENT_ERR_CAPTURE_EN.
module gcd_client
    import gcd_client_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_NBITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_val,
    output logic                 cmd_rdy,
    input  logic [CMD_W-1:0]     cmd_msg,
    output logic                 req_val,
    input  logic                 req_rdy,
    output logic [REQ_W-1:0]     req_msg,
    input  logic                 resp_val,
    output logic                 resp_rdy,
    input  logic [OPND_W-1:0]    resp_msg,
    output logic [CNT_NBITS-1:0] num_resp,
    output logic [CNT_NBITS-1:0] num_err,
    output logic                 idle
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
    ,
    output logic                 err_valid,
    output logic [OPND_W-1:0]    err_a,
    output logic [OPND_W-1:0]    err_b,
    output logic [OPND_W-1:0]    err_got,
    output logic [OPND_W-1:0]    err_exp
`endif
);
    localparam int IW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0]        ISS_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]        ISS_ZERO = {IW{1'b0}};
    localparam logic [CNT_NBITS-1:0] CNT_ONE  = {{(CNT_NBITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_NBITS-1:0] CNT_MAX  = {CNT_NBITS{1'b1}};

    logic                 cmd_go_s;
    logic                 req_go_s;
    logic                 resp_go_s;
    logic                 req_full_s;
    logic                 req_empty_s;
    logic                 exp_full_s;
    logic                 exp_empty_s;
    logic [REQ_W-1:0]     req_head_s;
    logic [EXP_W-1:0]     exp_wdata_s;
    logic [EXP_W-1:0]     exp_head_s;
    logic                 mismatch_s;
    logic [IW-1:0]        issued_r;
    logic [IW-1:0]        issued_nxt_s;
    logic [CNT_NBITS-1:0] num_resp_r;
    logic [CNT_NBITS-1:0] num_resp_nxt_s;
    logic [CNT_NBITS-1:0] num_err_r;
    logic [CNT_NBITS-1:0] num_err_nxt_s;

    // Handshake flags come only from queue state, never from the partner's val/rdy.
    assign cmd_rdy   = !req_full_s && !exp_full_s;
    assign req_val   = !req_empty_s;
    assign req_msg   = req_head_s;
    assign resp_rdy  = (issued_r != ISS_ZERO);
    assign idle      = req_empty_s && exp_empty_s;

    assign cmd_go_s  = cmd_val && cmd_rdy;
    assign req_go_s  = req_val && req_rdy;
    assign resp_go_s = resp_val && resp_rdy;

    assign mismatch_s = (resp_msg != exp_head_s[CMD_EXP_LSB +: OPND_W]);

`ifdef GCD_CLIENT_ERR_CAPTURE_EN
    assign exp_wdata_s = cmd_msg;
`else
    assign exp_wdata_s = cmd_expected(cmd_msg);
`endif

    gcd_client_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_go_s),
        .wdata (cmd_req_part(cmd_msg)),
        .pop   (req_go_s),
        .rdata (req_head_s),
        .full  (req_full_s),
        .empty (req_empty_s)
    );

    gcd_client_fifo #(
        .WIDTH (EXP_W),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_go_s),
        .wdata (exp_wdata_s),
        .pop   (resp_go_s),
        .rdata (exp_head_s),
        .full  (exp_full_s),
        .empty (exp_empty_s)
    );

    // Next values for the issued count and the status counters.
    always_comb begin
        issued_nxt_s   = issued_r;
        num_resp_nxt_s = num_resp_r;
        num_err_nxt_s  = num_err_r;
        case ({req_go_s, resp_go_s})
            2'b10:   issued_nxt_s = issued_r + ISS_ONE;
            2'b01:   issued_nxt_s = issued_r - ISS_ONE;
            default: issued_nxt_s = issued_r;
        endcase
        if (resp_go_s) begin
            num_resp_nxt_s = num_resp_r + CNT_ONE;
            // The error count sticks at all-ones rather than wrapping.
            if (mismatch_s && (num_err_r != CNT_MAX)) begin
                num_err_nxt_s = num_err_r + CNT_ONE;
            end else begin
                num_err_nxt_s = num_err_r;
            end
        end else begin
            num_resp_nxt_s = num_resp_r;
            num_err_nxt_s  = num_err_r;
        end
    end

    // Issued-count and status counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_r   <= ISS_ZERO;
            num_resp_r <= {CNT_NBITS{1'b0}};
            num_err_r  <= {CNT_NBITS{1'b0}};
        end else begin
            issued_r   <= issued_nxt_s;
            num_resp_r <= num_resp_nxt_s;
            num_err_r  <= num_err_nxt_s;
        end
    end

    assign num_resp = num_resp_r;
    assign num_err  = num_err_r;

`ifdef GCD_CLIENT_ERR_CAPTURE_EN
    logic              err_valid_r;
    logic [OPND_W-1:0] err_a_r;
    logic [OPND_W-1:0] err_b_r;
    logic [OPND_W-1:0] err_got_r;
    logic [OPND_W-1:0] err_exp_r;

    // Capture the first mismatch after reset and hold it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_r <= 1'b0;
            err_a_r     <= {OPND_W{1'b0}};
            err_b_r     <= {OPND_W{1'b0}};
            err_got_r   <= {OPND_W{1'b0}};
            err_exp_r   <= {OPND_W{1'b0}};
        end else if (resp_go_s && mismatch_s && !err_valid_r) begin
            err_valid_r <= 1'b1;
            err_a_r     <= req_a(cmd_req_part(exp_head_s));
            err_b_r     <= req_b(cmd_req_part(exp_head_s));
            err_got_r   <= resp_msg;
            err_exp_r   <= cmd_expected(exp_head_s);
        end else begin
            err_valid_r <= err_valid_r;
        end
    end

    assign err_valid = err_valid_r;
    assign err_a     = err_a_r;
    assign err_b     = err_b_r;
    assign err_got   = err_got_r;
    assign err_exp   = err_exp_r;
`endif

endmodule

// File: tb/tb_gcd_client.sv
// Bench for gcd_client: a queue-based model checked every cycle plus directed pinned checks.
// Two instances share stimulus; the second uses 2-bit counters to exercise wrap/saturation.
module tb_gcd_client;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_val;
    logic [47:0] cmd_msg;
    logic        req_rdy;
    logic        resp_val;
    logic [15:0] resp_msg;

    logic        cmd_rdy_a, req_val_a, resp_rdy_a, idle_a;
    logic [31:0] req_msg_a;
    logic [15:0] num_resp_a, num_err_a;
    logic        cmd_rdy_b, req_val_b, resp_rdy_b, idle_b;
    logic [31:0] req_msg_b;
    logic [1:0]  num_resp_b, num_err_b;
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
    logic        err_valid_a, err_valid_b;
    logic [15:0] err_a_a, err_b_a, err_got_a, err_exp_a;
    logic [15:0] err_a_b, err_b_b, err_got_b, err_exp_b;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gcd_client #(.DEPTH(DEPTH), .CNT_NBITS(16)) dut_a (
        .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy_a), .cmd_msg(cmd_msg),
        .req_val(req_val_a), .req_rdy(req_rdy), .req_msg(req_msg_a),
        .resp_val(resp_val), .resp_rdy(resp_rdy_a), .resp_msg(resp_msg),
        .num_resp(num_resp_a), .num_err(num_err_a), .idle(idle_a)
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
        , .err_valid(err_valid_a), .err_a(err_a_a), .err_b(err_b_a),
        .err_got(err_got_a), .err_exp(err_exp_a)
`endif
    );

    gcd_client #(.DEPTH(DEPTH), .CNT_NBITS(2)) dut_b (
        .clk(clk), .reset(reset), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy_b), .cmd_msg(cmd_msg),
        .req_val(req_val_b), .req_rdy(req_rdy), .req_msg(req_msg_b),
        .resp_val(resp_val), .resp_rdy(resp_rdy_b), .resp_msg(resp_msg),
        .num_resp(num_resp_b), .num_err(num_err_b), .idle(idle_b)
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
        , .err_valid(err_valid_b), .err_a(err_a_b), .err_b(err_b_b),
        .err_got(err_got_b), .err_exp(err_exp_b)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: commands accepted but not yet answered, and how many of them were issued.
    logic [47:0] pend_q[$];
    int          m_issued = 0;
    int          m_resp = 0;
    int          m_err = 0;
    bit          started = 1'b0;
    bit          m_cap_valid = 1'b0;
    logic [15:0] m_cap_a, m_cap_b, m_cap_got, m_cap_exp;

    always @(posedge clk) begin : model
        bit          can_cmd, can_req, can_resp;
        logic [47:0] h;
        if (reset) begin
            pend_q.delete();
            m_issued    = 0;
            m_resp      = 0;
            m_err       = 0;
            m_cap_valid = 1'b0;
            started     = 1'b1;
        end else begin
            can_cmd  = pend_q.size() < DEPTH;
            can_req  = pend_q.size() > m_issued;
            can_resp = m_issued > 0;
            if (resp_val && can_resp) begin
                h = pend_q.pop_front();
                m_issued--;
                m_resp++;
                if (resp_msg != h[15:0]) begin
                    m_err++;
                    if (!m_cap_valid) begin
                        m_cap_valid = 1'b1;
                        m_cap_a     = h[47:32];
                        m_cap_b     = h[31:16];
                        m_cap_got   = resp_msg;
                        m_cap_exp   = h[15:0];
                    end
                end
            end
            if (req_rdy && can_req) m_issued++;
            if (cmd_val && can_cmd) pend_q.push_back(cmd_msg);
        end
    end

    // Compare both instances against the model away from the active edge.
    always @(negedge clk) begin : compare
        logic [47:0] h2;
        bit          e_req_val;
        if (started) begin
            e_req_val = pend_q.size() > m_issued;
            chk("cmd_rdy_a",  64'(cmd_rdy_a),  64'(pend_q.size() < DEPTH));
            chk("cmd_rdy_b",  64'(cmd_rdy_b),  64'(pend_q.size() < DEPTH));
            chk("req_val_a",  64'(req_val_a),  64'(e_req_val));
            chk("req_val_b",  64'(req_val_b),  64'(e_req_val));
            chk("resp_rdy_a", 64'(resp_rdy_a), 64'(m_issued > 0));
            chk("resp_rdy_b", 64'(resp_rdy_b), 64'(m_issued > 0));
            chk("idle_a",     64'(idle_a),     64'(pend_q.size() == 0));
            chk("idle_b",     64'(idle_b),     64'(pend_q.size() == 0));
            if (e_req_val) begin
                h2 = pend_q[m_issued];
                chk("req_msg_a", 64'(req_msg_a), 64'(h2[47:16]));
                chk("req_msg_b", 64'(req_msg_b), 64'(h2[47:16]));
            end
            chk("num_resp_a", 64'(num_resp_a), 64'(m_resp % 65536));
            chk("num_resp_b", 64'(num_resp_b), 64'(m_resp % 4));
            chk("num_err_a",  64'(num_err_a),  64'((m_err > 65535) ? 65535 : m_err));
            chk("num_err_b",  64'(num_err_b),  64'((m_err > 3) ? 3 : m_err));
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
            chk("err_valid_a", 64'(err_valid_a), 64'(m_cap_valid));
            chk("err_valid_b", 64'(err_valid_b), 64'(m_cap_valid));
            if (m_cap_valid) begin
                chk("err_fields_a", {err_a_a, err_b_a, err_got_a, err_exp_a},
                    {m_cap_a, m_cap_b, m_cap_got, m_cap_exp});
                chk("err_fields_b", {err_a_b, err_b_b, err_got_b, err_exp_b},
                    {m_cap_a, m_cap_b, m_cap_got, m_cap_exp});
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        bit acc = 1'b0;
        cmd_msg = {a, b, e};
        cmd_val = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = cmd_rdy_a;
            tick();
        end
        cmd_val = 1'b0;
        chk("cmd_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send_resp(input logic [15:0] r);
        bit acc = 1'b0;
        resp_msg = r;
        resp_val = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = resp_rdy_a;
            tick();
        end
        resp_val = 1'b0;
        chk("resp_accepted", 64'(acc), 64'd1);
    endtask

    localparam logic [47:0] TBL [5] = '{
        {16'd12, 16'd8,  16'd4},
        {16'd9,  16'd6,  16'd3},
        {16'd10, 16'd4,  16'd2},
        {16'd7,  16'd5,  16'd1},
        {16'd99, 16'd33, 16'd33}
    };
    localparam logic [31:0] REQ_EXP [4] = '{32'h000C0008, 32'h00090006, 32'h000A0004, 32'h00070005};

    initial begin
        int n_acc;
        reset    = 1'b1;
        cmd_val  = 1'b0;
        cmd_msg  = 48'd0;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        resp_msg = 16'd0;
        repeat (2) tick();

        // Reset state
        chk("rst_cmd_rdy",  64'(cmd_rdy_a),  64'd1);
        chk("rst_req_val",  64'(req_val_a),  64'd0);
        chk("rst_resp_rdy", 64'(resp_rdy_a), 64'd0);
        chk("rst_idle",     64'(idle_a),     64'd1);
        chk("rst_num_resp", 64'(num_resp_a), 64'd0);
        chk("rst_num_err",  64'(num_err_a),  64'd0);
        reset = 1'b0;
        tick();

        // Single matching transaction
        req_rdy = 1'b1;
        send_cmd(16'd15, 16'd5, 16'd5);
        chk("t1_req_val", 64'(req_val_a), 64'd1);
        chk("t1_req_msg", 64'(req_msg_a), 64'h000F0005);
        send_resp(16'd5);
        chk("t1_num_resp", 64'(num_resp_a), 64'd1);
        chk("t1_num_err",  64'(num_err_a),  64'd0);
        chk("t1_idle",     64'(idle_a),     64'd1);

        // Single mismatching transaction
        send_cmd(16'd27, 16'd15, 16'd4);
        send_resp(16'd3);
        chk("t2_num_err",  64'(num_err_a),  64'd1);
        chk("t2_num_resp", 64'(num_resp_a), 64'd2);
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
        chk("t2_err_valid", 64'(err_valid_a), 64'd1);
        chk("t2_err_fields", {err_a_a, err_b_a, err_got_a, err_exp_a},
            {16'd27, 16'd15, 16'd3, 16'd4});
`endif

        // Response offered with nothing issued
        resp_val = 1'b1;
        resp_msg = 16'd7;
        for (int i = 0; i < 3; i++) begin
            chk("t3_resp_rdy", 64'(resp_rdy_a), 64'd0);
            tick();
        end
        resp_val = 1'b0;
        chk("t3_num_resp", 64'(num_resp_a), 64'd2);
        chk("t3_num_err",  64'(num_err_a),  64'd1);

        // Fill with requests stalled, then drain in order
        req_rdy = 1'b0;
        n_acc   = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_msg = TBL[i];
            cmd_val = 1'b1;
            if (cmd_rdy_a) n_acc++;
            if (i == 4) chk("t4_cmd_rdy_5th", 64'(cmd_rdy_a), 64'd0);
            tick();
        end
        cmd_val = 1'b0;
        chk("t4_accepted", 64'(n_acc), 64'd4);
        req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_req_val", 64'(req_val_a), 64'd1);
            chk("t4_req_msg", 64'(req_msg_a), 64'(REQ_EXP[i]));
            tick();
        end
        chk("t4_req_drained", 64'(req_val_a), 64'd0);
        send_resp(16'd4);
        send_resp(16'd3);
        send_resp(16'd2);
        send_resp(16'd1);
        chk("t4_num_resp", 64'(num_resp_a), 64'd6);
        chk("t4_num_err",  64'(num_err_a),  64'd1);

        // Reset with work queued and one request outstanding
        req_rdy = 1'b0;
        send_cmd(16'd2, 16'd2, 16'd2);
        send_cmd(16'd4, 16'd2, 16'd2);
        req_rdy = 1'b1;
        tick();
        req_rdy  = 1'b0;
        reset    = 1'b1;
        resp_val = 1'b1;
        resp_msg = 16'd2;
        tick();
        chk("t5_idle",     64'(idle_a),     64'd1);
        chk("t5_req_val",  64'(req_val_a),  64'd0);
        chk("t5_num_resp", 64'(num_resp_a), 64'd0);
        chk("t5_num_err",  64'(num_err_a),  64'd0);
        reset = 1'b0;
        tick();
        chk("t5_resp_rdy", 64'(resp_rdy_a), 64'd0);
        chk("t5_num_resp_hold", 64'(num_resp_a), 64'd0);
        resp_val = 1'b0;

        // Five mismatches: narrow counters wrap and saturate
        req_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send_cmd(16'(k + 2), 16'd1, 16'd5);
            send_resp(16'd1);
        end
        chk("t6_num_err_b",  64'(num_err_b),  64'd3);
        chk("t6_num_resp_b", 64'(num_resp_b), 64'd1);
        chk("t6_num_err_a",  64'(num_err_a),  64'd5);
        chk("t6_num_resp_a", 64'(num_resp_a), 64'd5);
`ifdef GCD_CLIENT_ERR_CAPTURE_EN
        chk("t6_err_fields", {err_a_a, err_b_a, err_got_a, err_exp_a},
            {16'd2, 16'd1, 16'd1, 16'd5});
`endif

        // Streaming with concurrent push, issue and response
        resp_val = 1'b1;
        resp_msg = 16'd1;
        cmd_val  = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cmd_msg = {16'(i + 1), 16'd1, (i % 3 == 0) ? 16'd7 : 16'd1};
            req_rdy = (i % 4 != 3);
            tick();
        end
        cmd_val = 1'b0;
        req_rdy = 1'b1;
        repeat (12) tick();
        resp_val = 1'b0;
        chk("t7_idle", 64'(idle_a), 64'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
